// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero, reset-time clear sweep. Optional write-to-read bypass: REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] in_read1_address,
    input  logic [ADDR_W-1:0] in_read2_address,
    input  logic [ADDR_W-1:0] in_write_address,
    input  logic [XLEN-1:0]   in_write_data,
    input  logic              in_write_enable,
    output logic [XLEN-1:0]   out_read1_data,
    output logic [XLEN-1:0]   out_read2_data,
    output logic              out_busy
);

    localparam logic [0:0]        ST_CLEAR  = 1'b0;
    localparam logic [0:0]        ST_READY  = 1'b1;
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam int                NUM_RD    = 2;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic [XLEN-1:0]   regs_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [XLEN-1:0]   mem_wdata;

    // The sweep and the user write share one array write port; reset blocks both.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mem_we    = 1'b0;
        mem_waddr = in_write_address;
        mem_wdata = in_write_data;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
                idx_d     = idx_q + FIRST_IDX;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                mem_we = in_write_enable && (in_write_address != '0);
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0]   rd_data;

    assign rd_addr[0] = in_read1_address;
    assign rd_addr[1] = in_read2_address;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic fwd_hit;
`ifdef REGFILE_BYPASS_EN
            assign fwd_hit = (state_q == ST_READY) && in_write_enable &&
                             (in_write_address != '0) && (in_write_address == rd_addr[gi]);
`else
            assign fwd_hit = 1'b0;
`endif
            // Array contents are undefined until the sweep finishes, so mask during CLEAR.
            assign rd_data[gi] = ((state_q == ST_CLEAR) || (rd_addr[gi] == '0)) ? '0 :
                                 fwd_hit ? in_write_data : regs_q[rd_addr[gi]];
        end
    endgenerate

    assign out_read1_data = rd_data[0];
    assign out_read2_data = rd_data[1];
    assign out_busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (DEPTH=32, XLEN=32).
module tb_regfile_param;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] rd1_addr = '0;
    logic [ADDR_W-1:0] rd2_addr = '0;
    logic [ADDR_W-1:0] wr_addr  = '0;
    logic [XLEN-1:0]   wr_data  = '0;
    logic              wr_en    = 1'b0;
    logic [XLEN-1:0]   rd1_data;
    logic [XLEN-1:0]   rd2_data;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_param #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_read1_address (rd1_addr),
        .in_read2_address (rd2_addr),
        .in_write_address (wr_addr),
        .in_write_data    (wr_data),
        .in_write_enable  (wr_en),
        .out_read1_data   (rd1_data),
        .out_read2_data   (rd2_data),
        .out_busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        rd1_addr = a1;
        rd2_addr = a2;
        #1;
    endtask

    // Releases reset and counts edges until busy drops; returns the count (bounded).
    task automatic release_and_count(output int n);
        rst = 1'b0;
        n   = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
    endtask

    int n;

    initial begin
        // Reset held two cycles
        rst = 1'b1;
        step();
        step();
        rd(5'd1, 5'd31);
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_rd1", rd1_data, 32'h0);
        check("reset_rd2", rd2_data, 32'h0);

        release_and_count(n);
        check("sweep_len", n, 32'd31);
        check("sweep_done_busy", {31'd0, busy}, 32'd0);
        rd(5'd1, 5'd17);
        check("post_sweep_x1", rd1_data, 32'h0);
        check("post_sweep_x17", rd2_data, 32'h0);
        rd(5'd31, 5'd0);
        check("post_sweep_x31", rd1_data, 32'h0);

        // Write/read on both ports
        wr(5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd5);
        check("x5_rd1", rd1_data, 32'hDEADBEEF);
        check("x5_rd2", rd2_data, 32'hDEADBEEF);

        // x0 protection
        wr(5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd0);
        check("x0_rd1", rd1_data, 32'h0);
        check("x0_rd2", rd2_data, 32'h0);

        // Same-cycle write/read of x7
        rd(5'd7, 5'd5);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", rd1_data, 32'h12345678);
`else
        check("bypass_same_cycle", rd1_data, 32'h0);
`endif
        check("bypass_other_port", rd2_data, 32'hDEADBEEF);
        step();
        wr_en = 1'b0;
        #1;
        check("bypass_next_cycle", rd1_data, 32'h12345678);

        // Fill x1..x31 with nonzero data
        for (int i = 1; i < DEPTH; i++) begin
            wr(ADDR_W'(i), 32'hA000_0000 | 32'(i));
        end
        rd(5'd1, 5'd31);
        check("fill_x1", rd1_data, 32'hA000_0001);
        check("fill_x31", rd2_data, 32'hA000_001F);

        // Second reset, interrupted at sweep step 10
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rd(5'd20, 5'd31);
        check("mid_sweep_busy", {31'd0, busy}, 32'd1);
        check("mid_sweep_rd_masked", rd1_data, 32'h0);
        rst = 1'b1;
        step();
        release_and_count(n);
        check("restart_sweep_len", n, 32'd31);
        for (int i = 1; i < DEPTH; i++) begin
            rd(ADDR_W'(i), ADDR_W'(i));
            if (rd1_data !== 32'h0 || rd2_data !== 32'h0)
                check($sformatf("cleared_x%0d", i), rd1_data | rd2_data, 32'h0);
        end
        rd(5'd10, 5'd30);
        check("cleared_x10", rd1_data, 32'h0);
        check("cleared_x30", rd2_data, 32'h0);

        // Write to x3 during the sweep, after x3 has already been cleared
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        wr(5'd3, 32'hAAAA5555);
        release_and_count(n);
        check("busy_write_sweep_len", n, 32'd10);
        rd(5'd3, 5'd3);
        check("busy_write_x3", rd1_data, 32'h0);

        // First cycle after busy falls accepts a write
        wr(5'd9, 32'h0BADF00D);
        rd(5'd9, 5'd3);
        check("ready_write_x9", rd1_data, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the RISC-V cores: two combinational read ports and one synchronous write port. Register 0 is hardwired to zero. A reset-time clear sequencer zeroes every register, one per cycle, and raises a busy flag while it runs. An optional same-cycle write-to-read bypass makes the block usable directly in the pipelined core's decode stage.

## Interface
Parameters:
- XLEN, 32, data width of each register in bits.
- DEPTH, 32, number of architectural registers. Must be a power of two and ≥ 2.
- ADDR_W, $clog2(DEPTH), address width. Derived; do not override.

Ports:
- clk  input  1  single clock. All state changes on rising edge.
- rst  input  1  reset: synchronous, active-high.
- in_read1_address  input  ADDR_W  read port 1 address.
- in_read2_address  input  ADDR_W  read port 2 address.
- in_write_address  input  ADDR_W  write port address.
- in_write_data  input  XLEN  write data.
- in_write_enable  input  1  write strobe, sampled at the rising edge.
- out_read1_data  output  XLEN  read port 1 data (combinational).
- out_read2_data  output  XLEN  read port 2 data (combinational).
- out_busy  output  1  high while the clear sweep runs. Writes are ignored and reads return 0 while it is high.

## Operation
- Two states: CLEAR and READY. A clear index register idx (ADDR_W bits) drives the sweep.
- rst high at an edge:
  - state <= CLEAR, idx <= 1.
  - No array write occurs, including any in_write_enable in that cycle.
- CLEAR with rst low, each edge:
  - registers[idx] <= 0 and idx <= idx + 1.
  - When idx == DEPTH-1, the final zero is written and state <= READY.
- READY with in_write_enable=1 and in_write_address != 0: registers[in_write_address] <= in_write_data at the edge. A write to address 0 is discarded.
- Reads, per port independently:
  - Address 0 returns 0.
  - In CLEAR, every read returns 0.
  - Otherwise the port returns the array contents, subject to the bypass rule under Configuration.
- out_busy = (state == CLEAR).
- Reset mid-sweep restarts the sweep at idx=1. No partial state survives.
- Both read ports may address the same register and must return identical data.
- DEPTH=2 corner: the sweep is one cycle (idx=1 is the last index).

## Timing
- Reset values: state=CLEAR, idx=1, out_busy=1, out_read1_data=0, out_read2_data=0.
- Sweep length: out_busy stays high for exactly DEPTH-1 rising edges after the first edge at which rst is low. For DEPTH=32 that is 31 cycles.
- out_busy falls combinationally after the edge that writes register DEPTH-1. A write presented in the cycle after that edge is accepted.
- Read latency is 0 cycles (combinational from address).
- Without bypass, written data is visible on a read port from the cycle after the write edge.
- Array registers have no reset of their own. They are defined only after the sweep completes; before that, reads are masked to 0.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: when state is READY, in_write_enable=1, in_write_address != 0 and in_write_address equals a read address, that read port returns in_write_data in the same cycle (write-first forwarding).
- Undefined: that read port returns the pre-write array value in the same cycle, and the new value from the next cycle.
- Address 0 and CLEAR masking apply in both builds. Write timing is identical in both builds.

## Test plan
- Reset sweep: assert rst for 2 cycles, release with DEPTH=32. Required: out_busy=1 for exactly 31 cycles then 0. Reads of addresses 1, 17 and 31 then return 0x00000000.
- Write/read: after the sweep, write 0xDEADBEEF to x5. The next cycle, read1=5 and read2=5 both return 0xDEADBEEF.
- x0 protection: write 0xFFFFFFFF to address 0. Required: read of address 0 returns 0 on both ports.
- Bypass: write 0x12345678 to x7 while read1=7 in the same cycle.
  - With REGFILE_BYPASS_EN: read1 shows 0x12345678 that cycle.
  - Without it: read1 shows the old value (0) that cycle and 0x12345678 the next.
- Reset mid-operation: fill x1–x31 with nonzero data, then assert rst at sweep step 10 of a second reset. Required: the sweep restarts (31 busy cycles from release) and all registers read 0.
- Writes during busy: pulse in_write_enable with address 3 and data 0xAAAA5555 while out_busy=1. Required: after the sweep, x3 reads 0.
